// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of bram_port_arbiter. Each request and response lane is flattened.
// Requester i occupies slice i of every vector.
interface bram_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int NUM_COL = 16,
  parameter int WIDTH   = 128
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr;
  logic [NUM_REQ*NUM_COL-1:0] req_bwe;
  logic [NUM_REQ*WIDTH-1:0]   req_wdata;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic [NUM_REQ*WIDTH-1:0]   rsp_data;

  modport master (
    output req_valid, req_addr, req_bwe, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_bwe, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter that shares the two ports of an output-registered, true dual-port,
// byte-write BRAM among NUM_REQ requesters. Each read response appears two cycles after
// its grant. Define BRAM_ARB_COLLISION_CHECK_EN to withhold port B when it pairs with
// port A on one address and either access is a write.
module bram_port_arbiter #(
  parameter int  NUM_REQ   = 4,
  parameter int  NUM_COL   = 16,
  parameter int  COL_WIDTH = 8,
  parameter int  DEPTH     = 2048,
  localparam int WIDTH     = NUM_COL * COL_WIDTH,
  // clogb2(DEPTH-1), never narrower than one bit
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_port_arbiter_if.slave    req_if,
  output logic [ADDR_W-1:0]     ram_addra,
  output logic [ADDR_W-1:0]     ram_addrb,
  output logic [WIDTH-1:0]      ram_dina,
  output logic [WIDTH-1:0]      ram_dinb,
  output logic [NUM_COL-1:0]    ram_byte_wea,
  output logic [NUM_COL-1:0]    ram_byte_web,
  output logic                  ram_ena,
  output logic                  ram_enb,
  output logic                  ram_oreg_ena,
  output logic                  ram_oreg_enb,
  output logic                  ram_rsta,
  output logic                  ram_rstb,
  input  logic [WIDTH-1:0]      ram_douta,
  input  logic [WIDTH-1:0]      ram_doutb
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDW-1:0] id_t;
  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

  id_t                rr_ptr_q, rr_ptr_d;
  id_t                scan_idx;
  logic               cand_a, cand_b;
  id_t                id_a, id_b;
  logic [ADDR_W-1:0]  addr_a, addr_b;
  logic [NUM_COL-1:0] bwe_a, bwe_b;
  logic [WIDTH-1:0]   wdata_a, wdata_b;
  logic               collide;
  logic               gnt_a, gnt_b;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_REQ*WIDTH-1:0] rsp_data;
  tag_t               s1a_d, s1b_d;
  tag_t               s1a_q, s1b_q, s2a_q, s2b_q;

  // Walk the requesters circularly from rr_ptr: first valid one -> port A, next -> port B.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    cand_a   = 1'b0;
    cand_b   = 1'b0;
    id_a     = '0;
    id_b     = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = id_t'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!rst && req_if.req_valid[scan_idx]) begin
        if (!cand_a) begin
          cand_a = 1'b1;
          id_a   = scan_idx;
        end else if (!cand_b) begin
          cand_b = 1'b1;
          id_b   = scan_idx;
        end
      end
    end
  end

  assign addr_a  = req_if.req_addr [id_a*ADDR_W  +: ADDR_W];
  assign addr_b  = req_if.req_addr [id_b*ADDR_W  +: ADDR_W];
  assign bwe_a   = req_if.req_bwe  [id_a*NUM_COL +: NUM_COL];
  assign bwe_b   = req_if.req_bwe  [id_b*NUM_COL +: NUM_COL];
  assign wdata_a = req_if.req_wdata[id_a*WIDTH   +: WIDTH];
  assign wdata_b = req_if.req_wdata[id_b*WIDTH   +: WIDTH];

`ifdef BRAM_ARB_COLLISION_CHECK_EN
  assign collide = cand_a && cand_b && (addr_a == addr_b) && ((|bwe_a) || (|bwe_b));
`else
  assign collide = 1'b0;
`endif

  assign gnt_a = cand_a;
  assign gnt_b = cand_b && !collide;

  always_comb begin
    ready = '0;
    if (gnt_a) ready[id_a] = 1'b1;
    if (gnt_b) ready[id_b] = 1'b1;
  end
  assign req_if.req_ready = ready;

  // A withheld port-B candidate stays ahead of the pointer and wins port A next cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_b)      rr_ptr_d = id_t'((int'(id_b) + 1) % NUM_REQ);
    else if (gnt_a) rr_ptr_d = id_t'((int'(id_a) + 1) % NUM_REQ);
  end

  assign ram_ena      = gnt_a;
  assign ram_enb      = gnt_b;
  assign ram_addra    = addr_a;
  assign ram_addrb    = addr_b;
  assign ram_dina     = wdata_a;
  assign ram_dinb     = wdata_b;
  assign ram_byte_wea = gnt_a ? bwe_a : '0;
  assign ram_byte_web = gnt_b ? bwe_b : '0;

  always_comb begin
    s1a_d = '{vld: gnt_a && (bwe_a == '0), id: id_a};
    s1b_d = '{vld: gnt_b && (bwe_b == '0), id: id_b};
  end

  // NOTE: state uses non-blocking assignments, and the reset is synchronous. Clearing both
  // tag stages drops any read that is still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      s1a_q    <= '0;
      s1b_q    <= '0;
      s2a_q    <= '0;
      s2b_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      s1a_q    <= s1a_d;
      s1b_q    <= s1b_d;
      s2a_q    <= s1a_q;
      s2b_q    <= s1b_q;
    end
  end

  assign ram_oreg_ena = s1a_q.vld && !rst;
  assign ram_oreg_enb = s1b_q.vld && !rst;
  assign ram_rsta     = rst;
  assign ram_rstb     = rst;

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (!rst) begin
      if (s2a_q.vld) begin
        rsp_valid[s2a_q.id]                = 1'b1;
        rsp_data[s2a_q.id*WIDTH +: WIDTH]  = ram_douta;
      end
      if (s2b_q.vld) begin
        rsp_valid[s2b_q.id]                = 1'b1;
        rsp_data[s2b_q.id*WIDTH +: WIDTH]  = ram_doutb;
      end
    end
  end

  assign req_if.rsp_valid = rsp_valid;
  assign req_if.rsp_data  = rsp_data;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter. A behavioural BRAM is attached to both ports, and every
// cycle is scored against a round-robin/scoreboard model built from the arbitration rules.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int NUM_COL   = 16;
  localparam int COL_WIDTH = 8;
  localparam int DEPTH     = 2048;
  localparam int WIDTH     = NUM_COL * COL_WIDTH;
  localparam int ADDR_W    = 11;

  typedef logic [WIDTH-1:0] word_t;
  typedef struct { int due; int id; word_t data; } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .NUM_COL(NUM_COL), .WIDTH(WIDTH)) rif ();

  logic [ADDR_W-1:0]  ram_addra, ram_addrb;
  logic [WIDTH-1:0]   ram_dina, ram_dinb, ram_douta, ram_doutb;
  logic [NUM_COL-1:0] ram_byte_wea, ram_byte_web;
  logic ram_ena, ram_enb, ram_oreg_ena, ram_oreg_enb, ram_rsta, ram_rstb;

  bram_port_arbiter #(.NUM_REQ(NUM_REQ), .NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_if(rif),
    .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_dina(ram_dina), .ram_dinb(ram_dinb),
    .ram_byte_wea(ram_byte_wea), .ram_byte_web(ram_byte_web), .ram_ena(ram_ena), .ram_enb(ram_enb),
    .ram_oreg_ena(ram_oreg_ena), .ram_oreg_enb(ram_oreg_enb), .ram_rsta(ram_rsta), .ram_rstb(ram_rstb),
    .ram_douta(ram_douta), .ram_doutb(ram_doutb)
  );

  function automatic word_t init_word(int a);
    word_t w;
    if (a == 5) return {NUM_COL{8'hAB}};
    for (int c = 0; c < NUM_COL; c++) w[c*COL_WIDTH +: COL_WIDTH] = 8'((a * 13 + c * 7 + 1) & 255);
    return w;
  endfunction

  // Behavioural read-first, output-registered true dual-port BRAM.
  logic  mem_init;
  word_t mem [DEPTH];
  word_t lat_a, lat_b;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= init_word(a);
    end else begin
      if (ram_ena) begin
        lat_a <= mem[ram_addra];
        for (int c = 0; c < NUM_COL; c++)
          if (ram_byte_wea[c]) mem[ram_addra][c*COL_WIDTH +: COL_WIDTH] <= ram_dina[c*COL_WIDTH +: COL_WIDTH];
      end
      if (ram_enb) begin
        lat_b <= mem[ram_addrb];
        for (int c = 0; c < NUM_COL; c++)
          if (ram_byte_web[c]) mem[ram_addrb][c*COL_WIDTH +: COL_WIDTH] <= ram_dinb[c*COL_WIDTH +: COL_WIDTH];
      end
    end
    if (ram_rsta) ram_douta <= '0; else if (ram_oreg_ena) ram_douta <= lat_a;
    if (ram_rstb) ram_doutb <= '0; else if (ram_oreg_enb) ram_doutb <= lat_b;
  end

  // Reference model state.
  word_t ref_mem [DEPTH];
  int    ref_ptr;
  exp_t  exp_q[$];
  int    cyc;
  int    n_tests, n_fail;

  // Values observed during the most recent step, for directed checks.
  logic [NUM_REQ-1:0] obs_ready, obs_rv;
  word_t              obs_rd [NUM_REQ];
  logic               obs_ena, obs_enb;
  logic [ADDR_W-1:0]  obs_addra;
  logic [1:0]         obs_oreg, obs_rst;

  function automatic logic [ADDR_W-1:0] addr_of(int i);
    return rif.req_addr[i*ADDR_W +: ADDR_W];
  endfunction
  function automatic logic [NUM_COL-1:0] bwe_of(int i);
    return rif.req_bwe[i*NUM_COL +: NUM_COL];
  endfunction
  function automatic word_t wdata_of(int i);
    return rif.req_wdata[i*WIDTH +: WIDTH];
  endfunction

  task automatic set_req(int i, logic v, logic [ADDR_W-1:0] a, logic [NUM_COL-1:0] be, word_t d);
    rif.req_valid[i]                  = v;
    rif.req_addr[i*ADDR_W +: ADDR_W]  = a;
    rif.req_bwe[i*NUM_COL +: NUM_COL] = be;
    rif.req_wdata[i*WIDTH +: WIDTH]   = d;
  endtask

  task automatic idle();
    rif.req_valid = '0;
    rif.req_addr  = '0;
    rif.req_bwe   = '0;
    rif.req_wdata = '0;
  endtask

  // One clock cycle: score the outputs against the model at the falling edge, then advance the model.
  task automatic step();
    int order[$];
    int ga, gb;
    logic [NUM_REQ-1:0] exp_ready, exp_rv;
    word_t exp_rd [NUM_REQ];
    @(negedge clk);
    ga = -1;
    gb = -1;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (rif.req_valid[(ref_ptr + k) % NUM_REQ]) order.push_back((ref_ptr + k) % NUM_REQ);
      if (order.size() > 0) ga = order[0];
      if (order.size() > 1) gb = order[1];
`ifdef BRAM_ARB_COLLISION_CHECK_EN
      if (gb >= 0 && addr_of(ga) == addr_of(gb) && (bwe_of(ga) != 0 || bwe_of(gb) != 0)) gb = -1;
`endif
    end
    exp_ready = '0;
    if (ga >= 0) exp_ready[ga] = 1'b1;
    if (gb >= 0) exp_ready[gb] = 1'b1;
    exp_rv = '0;
    for (int i = 0; i < NUM_REQ; i++) exp_rd[i] = '0;
    if (!rst)
      foreach (exp_q[j]) if (exp_q[j].due == cyc) begin
        exp_rv[exp_q[j].id] = 1'b1;
        exp_rd[exp_q[j].id] = exp_q[j].data;
      end

    obs_ready = rif.req_ready;
    obs_rv    = rif.rsp_valid;
    for (int i = 0; i < NUM_REQ; i++) obs_rd[i] = rif.rsp_data[i*WIDTH +: WIDTH];
    obs_ena   = ram_ena;
    obs_enb   = ram_enb;
    obs_addra = ram_addra;
    obs_oreg  = {ram_oreg_enb, ram_oreg_ena};
    obs_rst   = {ram_rstb, ram_rsta};

    n_tests++;
    if (obs_ready !== exp_ready) begin
      n_fail++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, obs_ready, exp_ready);
    end
    n_tests++;
    if ({obs_enb, obs_ena} !== {gb >= 0, ga >= 0}) begin
      n_fail++; $display("FAIL ram_en cyc=%0d got=%b exp=%b", cyc, {obs_enb, obs_ena}, {gb >= 0, ga >= 0});
    end
    if (ga >= 0) begin
      n_tests++;
      if (ram_addra !== addr_of(ga) || ram_byte_wea !== bwe_of(ga) || (bwe_of(ga) != 0 && ram_dina !== wdata_of(ga))) begin
        n_fail++; $display("FAIL port_a cyc=%0d got addr=%0d bwe=%h exp addr=%0d bwe=%h", cyc, ram_addra, ram_byte_wea, addr_of(ga), bwe_of(ga));
      end
    end else begin
      n_tests++;
      if (ram_byte_wea !== '0) begin
        n_fail++; $display("FAIL port_a_idle_bwe cyc=%0d got=%h exp=0", cyc, ram_byte_wea);
      end
    end
    if (gb >= 0) begin
      n_tests++;
      if (ram_addrb !== addr_of(gb) || ram_byte_web !== bwe_of(gb) || (bwe_of(gb) != 0 && ram_dinb !== wdata_of(gb))) begin
        n_fail++; $display("FAIL port_b cyc=%0d got addr=%0d bwe=%h exp addr=%0d bwe=%h", cyc, ram_addrb, ram_byte_web, addr_of(gb), bwe_of(gb));
      end
    end else begin
      n_tests++;
      if (ram_byte_web !== '0) begin
        n_fail++; $display("FAIL port_b_idle_bwe cyc=%0d got=%h exp=0", cyc, ram_byte_web);
      end
    end
    n_tests++;
    if (obs_rst !== {rst, rst}) begin
      n_fail++; $display("FAIL ram_rst cyc=%0d got=%b exp=%b", cyc, obs_rst, {rst, rst});
    end
    n_tests++;
    if (obs_rv !== exp_rv) begin
      n_fail++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, obs_rv, exp_rv);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      n_tests++;
      if (obs_rd[i] !== exp_rd[i]) begin
        n_fail++; $display("FAIL rsp_data[%0d] cyc=%0d got=%h exp=%h", i, cyc, obs_rd[i], exp_rd[i]);
      end
    end

    while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
    if (rst) begin
      exp_q.delete();
      ref_ptr = 0;
    end else begin
      // Reads see memory contents from before this cycle's writes.
      if (ga >= 0 && bwe_of(ga) == 0) exp_q.push_back('{due: cyc + 2, id: ga, data: ref_mem[addr_of(ga)]});
      if (gb >= 0 && bwe_of(gb) == 0) exp_q.push_back('{due: cyc + 2, id: gb, data: ref_mem[addr_of(gb)]});
      foreach (order[j]) if (order[j] == ga || order[j] == gb)
        for (int c = 0; c < NUM_COL; c++)
          if (bwe_of(order[j])[c])
            ref_mem[addr_of(order[j])][c*COL_WIDTH +: COL_WIDTH] = wdata_of(order[j])[c*COL_WIDTH +: COL_WIDTH];
      if (gb >= 0)      ref_ptr = (gb + 1) % NUM_REQ;
      else if (ga >= 0) ref_ptr = (ga + 1) % NUM_REQ;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, ADDR_W'(i), '0, '0);
    step();
    step();
    n_tests++;
    if (obs_ready !== '0 || obs_ena !== 1'b0 || obs_enb !== 1'b0) begin
      n_fail++; $display("FAIL reset_grants got ready=%b en=%b%b exp=0", obs_ready, obs_enb, obs_ena);
    end
    n_tests++;
    if (obs_oreg !== 2'b00 || obs_rst !== 2'b11 || obs_rv !== '0) begin
      n_fail++; $display("FAIL reset_ram got oreg=%b rst=%b rv=%b exp oreg=00 rst=11 rv=0", obs_oreg, obs_rst, obs_rv);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 11'd5, '0, '0);
    step();
    n_tests++;
    if (obs_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_read_ready got=%b exp=0001", obs_ready);
    end
    idle();
    step();
    n_tests++;
    if (obs_rv !== 4'b0000 || obs_oreg !== 2'b01) begin
      n_fail++; $display("FAIL single_read_t1 got rv=%b oreg=%b exp rv=0000 oreg=01", obs_rv, obs_oreg);
    end
    step();
    n_tests++;
    if (obs_rv !== 4'b0001 || obs_rd[0] !== {NUM_COL{8'hAB}}) begin
      n_fail++; $display("FAIL single_read_t2 got rv=%b data=%h exp rv=0001 data=%h", obs_rv, obs_rd[0], {NUM_COL{8'hAB}});
    end
    step();
    n_tests++;
    if (obs_rv !== 4'b0000) begin
      n_fail++; $display("FAIL single_read_t3 got rv=%b exp=0000", obs_rv);
    end
  endtask

  task automatic test_back_to_back();
    reset_pulse();
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, ADDR_W'($urandom_range(0, 255)), '0, '0);
      step();
      n_tests++;
      if (obs_ready !== ((k % 2 == 0) ? 4'b0011 : 4'b1100)) begin
        n_fail++; $display("FAIL b2b_grant k=%0d got=%b exp=%b", k, obs_ready, (k % 2 == 0) ? 4'b0011 : 4'b1100);
      end
      if (k >= 2) begin
        n_tests++;
        if (obs_rv !== ((k % 2 == 0) ? 4'b0011 : 4'b1100)) begin
          n_fail++; $display("FAIL b2b_rsp k=%0d got=%b exp=%b", k, obs_rv, (k % 2 == 0) ? 4'b0011 : 4'b1100);
        end
      end
    end
    idle();
    step();
    step();
  endtask

  task automatic test_write_then_read();
    word_t expd;
    expd = init_word(7);
    expd[7:0] = 8'h5A;
    set_req(2, 1'b1, 11'd7, 16'h0001, {{(WIDTH-8){1'b1}}, 8'h5A});
    step();
    n_tests++;
    if (obs_ready !== 4'b0100) begin
      n_fail++; $display("FAIL wr_ready got=%b exp=0100", obs_ready);
    end
    idle();
    set_req(3, 1'b1, 11'd7, '0, '0);
    step();
    n_tests++;
    if (obs_ready !== 4'b1000) begin
      n_fail++; $display("FAIL rd_ready got=%b exp=1000", obs_ready);
    end
    idle();
    step();
    step();
    n_tests++;
    if (obs_rv !== 4'b1000 || obs_rd[3] !== expd) begin
      n_fail++; $display("FAIL byte_write got rv=%b data=%h exp rv=1000 data=%h", obs_rv, obs_rd[3], expd);
    end
  endtask

  task automatic test_collision();
    word_t d;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    reset_pulse();
    set_req(0, 1'b1, 11'd9, '1, d);
    set_req(1, 1'b1, 11'd9, '0, '0);
    step();
`ifdef BRAM_ARB_COLLISION_CHECK_EN
    n_tests++;
    if (obs_ready !== 4'b0001) begin
      n_fail++; $display("FAIL collide_hold got=%b exp=0001", obs_ready);
    end
    set_req(0, 1'b0, '0, '0, '0);
    step();
    n_tests++;
    if (obs_ready !== 4'b0010) begin
      n_fail++; $display("FAIL collide_retry got=%b exp=0010", obs_ready);
    end
    idle();
    step();
    step();
    n_tests++;
    if (obs_rv !== 4'b0010 || obs_rd[1] !== d) begin
      n_fail++; $display("FAIL collide_data got rv=%b data=%h exp rv=0010 data=%h", obs_rv, obs_rd[1], d);
    end
`else
    n_tests++;
    if (obs_ready !== 4'b0011) begin
      n_fail++; $display("FAIL no_collide_check got=%b exp=0011", obs_ready);
    end
    idle();
    step();
    step();
`endif
  endtask

  task automatic test_reset_inflight();
    reset_pulse();
    set_req(0, 1'b1, 11'd3, '0, '0);
    step();
    rst = 1'b1;
    idle();
    step();
    n_tests++;
    if (obs_rv !== '0) begin
      n_fail++; $display("FAIL inflight_t1 got=%b exp=0000", obs_rv);
    end
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, ADDR_W'(20 + i), '0, '0);
    step();
    n_tests++;
    if (obs_rv !== '0 || obs_ready !== 4'b0011) begin
      n_fail++; $display("FAIL inflight_release got rv=%b ready=%b exp rv=0000 ready=0011", obs_rv, obs_ready);
    end
    reset_pulse();
    set_req(3, 1'b1, 11'd42, '0, '0);
    step();
    n_tests++;
    if (obs_ready !== 4'b1000 || obs_ena !== 1'b1 || obs_addra !== 11'd42 || obs_enb !== 1'b0) begin
      n_fail++; $display("FAIL req3_port_a got ready=%b ena=%b addra=%0d enb=%b exp 1000 1 42 0", obs_ready, obs_ena, obs_addra, obs_enb);
    end
    idle();
    step();
    step();
  endtask

  task automatic test_random();
    logic [NUM_COL-1:0] be;
    logic [ADDR_W-1:0]  a;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          a  = ADDR_W'(i * 32 + $urandom_range(0, 31));
          be = NUM_COL'($urandom());
          if (be == '0) be = 1;
        end else begin
          a  = ADDR_W'($urandom_range(0, 127));
          be = '0;
        end
        set_req(i, $urandom_range(0, 9) < 7, a, be, {$urandom(), $urandom(), $urandom(), $urandom()});
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    ref_ptr  = 0;
    rst      = 1'b1;
    mem_init = 1'b1;
    idle();
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_then_read();
    test_collision();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
